// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous-read imem, buffers (inst, pc) in a small FIFO.
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirects trap into FAULT and raise sticky align_err.
//
// state    | meaning
// ST_RUN   | issuing word reads whenever a FIFO slot can be reserved
// ST_HALT  | pc word index beyond IMEM_WORDS; no requests, FIFO still drains
// ST_FAULT | misaligned redirect seen (FETCH_ALIGN_CHECK_EN only); held until rst
module riscv_fetch_unit #(
    parameter int          IMEM_AW    = 6,
    parameter int          IMEM_WORDS = 40,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_address0,
    output logic               imem_ce0,
    input  logic [31:0]        imem_q0,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst_data,
    output logic [31:0]        inst_pc,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               fetch_halt,
    output logic               align_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);
    localparam logic [29:0]   WORDS_W = 30'(IMEM_WORDS);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;
    logic redirect_mis;
    logic align_err_q;
`else
    typedef enum logic [1:0] {ST_RUN, ST_HALT} state_t;
`endif

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_seq;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop, push, slot_free, pc_in_range, seq_in_range;

    assign pc_seq        = pc_q + 32'd4;
    // Full 30-bit word index compare so far-out PCs cannot alias into the ROM range.
    assign pc_in_range   = pc_q[31:2] < WORDS_W;
    assign seq_in_range  = pc_seq[31:2] < WORDS_W;
    assign inst_valid    = count_q != '0;
    assign pop           = inst_valid & inst_ready & ~redirect_valid;
    assign push          = inflight_q & ~redirect_valid;
    // A request is only made if its response is guaranteed a slot when it lands.
    assign slot_free     = ({1'b0, count_q} + OW'(inflight_q)) < (DEPTH_W + OW'(pop));
    assign imem_address0 = pc_q[IMEM_AW+1:2];
    assign inst_data     = mem_data[rd_ptr_q];
    assign inst_pc       = mem_pc[rd_ptr_q];
    assign fetch_halt    = state_q == ST_HALT;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_mis = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign align_err    = align_err_q;

    always_ff @(posedge clk) begin
        if (rst)               align_err_q <= 1'b0;
        else if (redirect_mis) align_err_q <= 1'b1;
    end
`else
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        imem_ce0 = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!rst && !redirect_valid && pc_in_range && slot_free)
                    imem_ce0 = 1'b1;
                if (imem_ce0 ? !seq_in_range : !pc_in_range)
                    state_d = ST_HALT;
            end
            default: ;
        endcase
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (state_q == ST_FAULT || redirect_mis) state_d = ST_FAULT;
            else                                     state_d = ST_RUN;
`else
            state_d = ST_RUN;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            inflight_q <= imem_ce0;
            if (imem_ce0) begin
                pc_q          <= pc_seq;
                inflight_pc_q <= pc_q;
            end
            if (redirect_valid) begin
                pc_q     <= redirect_pc & ~32'h3;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    mem_data[wr_ptr_q] <= imem_q0;
                    mem_pc[wr_ptr_q]   <= inflight_pc_q;
                    wr_ptr_q           <= wr_ptr_q + PW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: ROM model, expected-delivery queue checked on every accepted handshake.
// Define FETCH_ALIGN_CHECK_EN for both files to exercise the alignment trap.
module tb_riscv_fetch_unit;
    localparam int IMEM_AW    = 6;
    localparam int IMEM_WORDS = 40;
    localparam int DEPTH      = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [IMEM_AW-1:0] imem_address0;
    logic               imem_ce0;
    logic [31:0]        imem_q0 = 32'h0;
    logic               inst_valid;
    logic               inst_ready = 1'b0;
    logic [31:0]        inst_data;
    logic [31:0]        inst_pc;
    logic               redirect_valid = 1'b0;
    logic [31:0]        redirect_pc = 32'h0;
    logic               fetch_halt;
    logic               align_err;

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    logic [63:0] sb_q[$];
    logic [63:0] sb_exp;

    riscv_fetch_unit #(
        .IMEM_AW(IMEM_AW), .IMEM_WORDS(IMEM_WORDS), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_address0(imem_address0), .imem_ce0(imem_ce0), .imem_q0(imem_q0),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_halt(fetch_halt), .align_err(align_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [IMEM_AW-1:0] a);
        if (int'(a) < IMEM_WORDS) return 32'h1000 + 32'(a);
        return 32'hBAD0_0000 | 32'(a);
    endfunction

    always @(posedge clk) if (imem_ce0 === 1'b1) imem_q0 <= rom_word(imem_address0);

    // Scoreboard: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && redirect_valid === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL deliver_unexpected got data=%h pc=%h, none expected", inst_data, inst_pc);
            end else begin
                sb_exp = sb_q.pop_front();
                if ({inst_data, inst_pc} !== sb_exp) begin
                    failures++;
                    $display("FAIL deliver got data=%h pc=%h want data=%h pc=%h",
                             inst_data, inst_pc, sb_exp[63:32], sb_exp[31:0]);
                end
            end
            delivered++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int first);
        for (int i = first; i < IMEM_WORDS; i++)
            sb_q.push_back({32'h1000 + 32'(i), 32'(i * 4)});
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        sb_q.delete();
        step(); step(); #1;
        checks++;
        if ({imem_ce0, inst_valid, fetch_halt, align_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got ce0/valid/halt/align=%b want 0000",
                     {imem_ce0, inst_valid, fetch_halt, align_err});
        end
        checks++;
        if ({inst_data, inst_pc} !== 64'h0) begin
            failures++;
            $display("FAIL reset_head got data=%h pc=%h want 0/0", inst_data, inst_pc);
        end
        checks++;
        if (imem_address0 !== '0) begin
            failures++;
            $display("FAIL reset_addr got %h want 0", imem_address0);
        end
    endtask

    task automatic test_streaming();
        int gaps = 0;
        step(); rst = 1'b0; inst_ready = 1'b1; sb_q.delete(); push_range(0); #1;
        checks++;
        if (imem_ce0 !== 1'b1 || imem_address0 !== 6'd0) begin
            failures++;
            $display("FAIL stream_first_req got ce0=%b addr=%0d want 1/0", imem_ce0, imem_address0);
        end
        step(); #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_latency1 got valid=%b want 0", inst_valid);
        end
        step(); #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_data !== 32'h1000 || inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL stream_latency2 got valid=%b data=%h pc=%h want 1/1000/0",
                     inst_valid, inst_data, inst_pc);
        end
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            if (inst_valid !== 1'b1) gaps++;
        end
        checks++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL stream_throughput got %0d bubbles want 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int d0;
        step(); rst = 1'b1; inst_ready = 1'b0; sb_q.delete();
        step(); rst = 1'b0; push_range(0);
        step();
        step(); #1;
        checks++;
        if (inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_first_valid got %b want 1", inst_valid);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin step(); #1; end
            checks++;
            if (imem_ce0 !== 1'b0) begin
                failures++;
                $display("FAIL bp_ce0_stall cycle %0d got ce0=%b want 0", k, imem_ce0);
            end
            checks++;
            if (inst_data !== 32'h1000 || inst_pc !== 32'h0) begin
                failures++;
                $display("FAIL bp_head_hold cycle %0d got data=%h pc=%h want 1000/0", k, inst_data, inst_pc);
            end
        end
        d0 = delivered;
        step(); inst_ready = 1'b1;
        while (delivered < d0 + 8 && n < 30) begin step(); n++; end
        checks++;
        if (delivered < d0 + 8) begin
            failures++;
            $display("FAIL bp_release got %0d deliveries want 8", delivered - d0);
        end
    endtask

    task automatic test_redirect();
        int n = 0;
        int d0;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h20; sb_q.delete(); push_range(8); #1;
        checks++;
        if (imem_ce0 !== 1'b0) begin
            failures++;
            $display("FAIL redir_no_issue got ce0=%b want 0", imem_ce0);
        end
        step(); redirect_valid = 1'b0; #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_flush got valid=%b want 0", inst_valid);
        end
        checks++;
        if (imem_ce0 !== 1'b1 || imem_address0 !== 6'd8) begin
            failures++;
            $display("FAIL redir_target got ce0=%b addr=%0d want 1/8", imem_ce0, imem_address0);
        end
        d0 = delivered;
        while (delivered < d0 + 4 && n < 20) begin step(); n++; end
        // Redirect while the FIFO is full and the consumer is stalled.
        inst_ready = 1'b0;
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h40; sb_q.delete(); push_range(16);
        step(); redirect_valid = 1'b0; inst_ready = 1'b1; #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_full_flush got valid=%b want 0", inst_valid);
        end
        d0 = delivered; n = 0;
        while (delivered < d0 + 3 && n < 20) begin step(); n++; end
        checks++;
        if (delivered < d0 + 3) begin
            failures++;
            $display("FAIL redir_resume got %0d deliveries want 3", delivered - d0);
        end
    endtask

    task automatic test_halt();
        int n = 0;
        int d0;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h98; sb_q.delete(); push_range(38);
        step(); redirect_valid = 1'b0; #1;
        checks++;
        if (imem_ce0 !== 1'b1 || imem_address0 !== 6'd38 || fetch_halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_w38 got ce0=%b addr=%0d halt=%b want 1/38/0", imem_ce0, imem_address0, fetch_halt);
        end
        step(); #1;
        checks++;
        if (imem_ce0 !== 1'b1 || imem_address0 !== 6'd39) begin
            failures++;
            $display("FAIL halt_w39 got ce0=%b addr=%0d want 1/39", imem_ce0, imem_address0);
        end
        step(); #1;
        checks++;
        if (fetch_halt !== 1'b1 || imem_ce0 !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter got halt=%b ce0=%b want 1/0", fetch_halt, imem_ce0);
        end
        while (sb_q.size() != 0 && n < 10) begin step(); n++; end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL halt_drain got %0d undelivered want 0", sb_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            checks++;
            if (inst_valid !== 1'b0 || imem_ce0 !== 1'b0 || fetch_halt !== 1'b1) begin
                failures++;
                $display("FAIL halt_idle got valid=%b ce0=%b halt=%b want 0/0/1", inst_valid, imem_ce0, fetch_halt);
            end
        end
        // Word 64 truncates to address 0 but must still be out of range.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h100; sb_q.delete();
        step(); redirect_valid = 1'b0; #1;
        checks++;
        if (imem_ce0 !== 1'b0) begin
            failures++;
            $display("FAIL halt_far_pc got ce0=%b want 0", imem_ce0);
        end
        step(); #1;
        checks++;
        if (fetch_halt !== 1'b1 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_far_state got halt=%b valid=%b want 1/0", fetch_halt, inst_valid);
        end
        step(); redirect_valid = 1'b1; redirect_pc = 32'h0; push_range(0);
        step(); redirect_valid = 1'b0; #1;
        checks++;
        if (fetch_halt !== 1'b0 || imem_ce0 !== 1'b1 || imem_address0 !== 6'd0) begin
            failures++;
            $display("FAIL halt_resume got halt=%b ce0=%b addr=%0d want 0/1/0", fetch_halt, imem_ce0, imem_address0);
        end
        d0 = delivered; n = 0;
        while (delivered < d0 + 3 && n < 20) begin step(); n++; end
        checks++;
        if (delivered < d0 + 3) begin
            failures++;
            $display("FAIL halt_resume_deliver got %0d want 3", delivered - d0);
        end
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        int d0;
        inst_ready = 1'b0;
        step();
        inst_ready = 1'b1;
        step(); rst = 1'b1; sb_q.delete();
        step(); #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_ce0 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear got valid=%b ce0=%b want 0/0", inst_valid, imem_ce0);
        end
        step(); rst = 1'b0; push_range(0); #1;
        checks++;
        if (imem_ce0 !== 1'b1 || imem_address0 !== 6'd0) begin
            failures++;
            $display("FAIL midrst_restart got ce0=%b addr=%0d want 1/0", imem_ce0, imem_address0);
        end
        step(); step(); #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h1000) begin
            failures++;
            $display("FAIL midrst_first got valid=%b data=%h pc=%h want 1/1000/0", inst_valid, inst_data, inst_pc);
        end
        d0 = delivered;
        while (delivered < d0 + 3 && n < 20) begin step(); n++; end
    endtask

    task automatic test_align();
        int n = 0;
        int d0;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h22; sb_q.delete();
`ifndef FETCH_ALIGN_CHECK_EN
        push_range(8);
`endif
        step(); redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin step(); #1; end
            checks++;
            if (align_err !== 1'b1 || imem_ce0 !== 1'b0 || inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL align_fault cycle %0d got err=%b ce0=%b valid=%b want 1/0/0",
                         k, align_err, imem_ce0, inst_valid);
            end
        end
`else
        checks++;
        if (align_err !== 1'b0 || imem_ce0 !== 1'b1 || imem_address0 !== 6'd8) begin
            failures++;
            $display("FAIL align_masked got err=%b ce0=%b addr=%0d want 0/1/8", align_err, imem_ce0, imem_address0);
        end
        d0 = delivered;
        while (delivered < d0 + 3 && n < 20) begin step(); n++; end
        checks++;
        if (delivered < d0 + 3 || align_err !== 1'b0) begin
            failures++;
            $display("FAIL align_masked_run got %0d deliveries err=%b want 3/0", delivered - d0, align_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_midstream();
        test_align();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
Instruction fetch stage between the riscv_kernel decode logic and the synchronous-read instruction ROM (riscv_kernel_imem).
- Owns the program counter and issues word reads on the imem port.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents them downstream on a valid/ready handshake.
- Supports PC redirect (branch/jump), which flushes all buffered and in-flight instructions.

Parameters:
IMEM_AW, 6, imem word-address width (imem_address0 width)
IMEM_WORDS, 40, number of valid ROM words; fetch stops at this bound
DEPTH, 2, instruction FIFO entries (power of two, >=2)
RESET_PC, 32'h0, byte PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_address0  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
imem_ce0  out  1  read request
imem_q0  in  32  ROM data, valid in cycle after request, held while ce0 low
inst_valid  out  1  FIFO head valid
inst_ready  in  1  downstream accepts head
inst_data  out  32  instruction at head
inst_pc  out  32  byte PC of head
redirect_valid  in  1  load new PC, flush
redirect_pc  in  32  redirect target (byte address)
fetch_halt  out  1  PC beyond IMEM_WORDS, no further requests
align_err  out  1  sticky misaligned-redirect flag

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - pc=RESET_PC; FIFO emptied; in-flight flag cleared.
  - imem_ce0=0, inst_valid=0, fetch_halt=0, align_err=0; inst_data/inst_pc=0.
  - Reset mid-operation discards any in-flight response.
- State machine:
  - RUN: issuing.
  - HALT: pc word index >= IMEM_WORDS; fetch_halt=1, ce0=0, FIFO still drains.
  - FAULT: only with the optional feature; ce0=0, align_err=1.
  - Exits: redirect_valid leaves HALT; rst leaves FAULT.
- Issue rule (combinational):
  - ce0=1 iff state==RUN, not redirect_valid this cycle, and count + inflight - pop < DEPTH.
  - pop = inst_valid & inst_ready.
  - On issue: pc += 4 at the edge; inflight=1 next cycle.
- Response: when inflight=1, imem_q0 and the issued PC are written to the FIFO tail at the end of that cycle.
- Latency:
  - Request in cycle N → response captured end of N+1 → inst_valid in N+2.
  - First inst_valid is 2 cycles after rst deasserts.
- Throughput: 1 instruction/cycle with inst_ready held high.
- Downstream stall: the issue rule guarantees no overflow; an in-flight response always has a slot.
- FIFO outputs: inst_data/inst_pc come from a registered head and are stable while inst_valid=1 and inst_ready=0.
- Redirect (redirect_valid=1 at an edge):
  - FIFO cleared; an in-flight response arriving in the same or next cycle is discarded; pc=redirect_pc; state=RUN.
  - No issue in the redirect cycle; first request to redirect_pc the next cycle.
  - Overrides a simultaneous pop.
  - inst_valid=0 the cycle after redirect.
  - redirect_pc[1:0] is ignored (forced to 0) unless the optional feature is enabled.
- Halt boundary: an issue of the last word (index IMEM_WORDS-1) moves the state to HALT at that edge; its response is still delivered.
- Address: imem_address0 = pc[IMEM_AW+1:2], driven even when ce0=0.
- Arithmetic: pc is 32-bit and wraps modulo 2^32. The HALT check uses the full pc>>2 compare, not a truncated index.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 flushes as normal, enters FAULT, and sets align_err=1 (sticky until rst). No further requests; an in-flight response is discarded.
- Undefined: low bits are masked, align_err is tied 0, and the FAULT state is absent.

Test Plan:
- Streaming: ROM word i = 32'h1000+i, rst released, inst_ready=1 → inst_valid rises 2 cycles later; inst_data 0x1000,0x1001,… one per cycle; inst_pc 0,4,8,…
- Backpressure: inst_ready=0 for 5 cycles after the first valid → ce0 stops after FIFO+inflight=DEPTH. Head holds 0x1000/pc 0. No loss or duplication on release.
- Redirect: redirect to 0x20 while a response is in flight and the FIFO holds 2 entries → next delivered inst_pc=0x20, data 0x1008. No stale entries.
- Halt: redirect to 0x98 (word 38) → delivers words 38 and 39, then fetch_halt=1 and ce0=0. A later redirect to 0x0 resumes with 0x1000.
- Reset mid-stream: rst pulse while the FIFO is full and a request is in flight → next cycle inst_valid=0, ce0=0. Fetch restarts at RESET_PC.
- Alignment (macro on): redirect to 0x22 → align_err=1, ce0 stays 0, inst_valid=0. With the macro off, fetch proceeds from 0x20.
